// File: rtl/instruction_fetch.sv
// IF stage: drives PC to instruction memory and registers the fetched word and PC+4 into IF/ID.
// Optional build macro IF_PERF_COUNT_EN adds fetch_count/bubble_count performance counters.
module instruction_fetch #(
   parameter int             n        = 32,
   parameter logic [n-1:0]   RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          freeze,
   input  logic          branch_taken,
   input  logic [n-1:0]  branch_addr,
   output logic [n-1:0]  PC,
   input  logic [n-1:0]  instruction,
   output logic [n-1:0]  if_pc_plus4,
   output logic [n-1:0]  if_instruction,
   output logic          if_valid
`ifdef IF_PERF_COUNT_EN
   ,
   output logic [n-1:0]  fetch_count,
   output logic [n-1:0]  bubble_count
`endif
);

   localparam logic [n-1:0] PC_STEP       = n'(4);
   localparam logic [n-1:0] RESET_PC_WORD = {RESET_PC[n-1:2], 2'b00};

   typedef enum logic {
      BOOT,
      RUN
   } state_t;

   state_t        r_state;
   logic [n-1:0]  r_pc;
   logic [n-1:0]  r_if_pc_plus4;
   logic [n-1:0]  r_if_instruction;
   logic          r_if_valid;

   logic [n-1:0]  w_pc_plus4;
   logic [n-1:0]  w_branch_target;
   logic          w_unused_addr_lsbs;

   // Targets are word aligned; the low address bits are dropped so the PC never leaves a word boundary.
   assign w_pc_plus4         = r_pc + PC_STEP;
   assign w_branch_target    = {branch_addr[n-1:2], 2'b00};
   assign w_unused_addr_lsbs = ^branch_addr[1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state          <= BOOT;
         r_pc             <= RESET_PC_WORD;
         r_if_pc_plus4    <= '0;
         r_if_instruction <= '0;
         r_if_valid       <= 1'b0;
      end else begin
         case (r_state)
            BOOT: begin
               // Memory output is not trusted on the first cycle out of reset.
               r_state          <= RUN;
               r_if_pc_plus4    <= '0;
               r_if_instruction <= '0;
               r_if_valid       <= 1'b0;
            end
            RUN: begin
               if (branch_taken) begin
                  r_pc             <= w_branch_target;
                  r_if_pc_plus4    <= '0;
                  r_if_instruction <= '0;
                  r_if_valid       <= 1'b0;
               end else if (!freeze) begin
                  r_pc             <= w_pc_plus4;
                  r_if_pc_plus4    <= w_pc_plus4;
                  r_if_instruction <= instruction;
                  r_if_valid       <= 1'b1;
               end
            end
            default: r_state <= BOOT;
         endcase
      end
   end

   assign PC             = r_pc;
   assign if_pc_plus4    = r_if_pc_plus4;
   assign if_instruction = r_if_instruction;
   assign if_valid       = r_if_valid;

`ifdef IF_PERF_COUNT_EN
   logic [n-1:0] r_fetch_count;
   logic [n-1:0] r_bubble_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fetch_count  <= '0;
         r_bubble_count <= '0;
      end else if (r_state == BOOT || branch_taken) begin
         r_bubble_count <= r_bubble_count + n'(1);
      end else if (!freeze) begin
         r_fetch_count  <= r_fetch_count + n'(1);
      end
   end

   assign fetch_count  = r_fetch_count;
   assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a driver queues expected PC/IF-ID values per cycle, a monitor checks them.
// Two instances: RESET_PC=0 for the main sequences, RESET_PC=0xFFFFFFFC for wrap-around (and counters with IF_PERF_COUNT_EN).
module tb_instruction_fetch;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] fcnt;
      logic [31:0] bcnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst0 = 1'b0, freeze0 = 1'b0, bt0 = 1'b0;
   logic [31:0] ba0 = '0;
   logic [31:0] pc0, instr0, pc4_0, ins_out0;
   logic        valid0;
   logic        rst1 = 1'b0;
   logic [31:0] pc1, instr1, pc4_1, ins_out1;
   logic        valid1;
   logic [31:0] fc0, bc0, fc1, bc1;

   logic [31:0] mem [64];
   exp_t        q0 [$];
   exp_t        q1 [$];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   assign instr0 = mem[pc0[7:2]];
   assign instr1 = mem[pc1[7:2]];

   instruction_fetch #(.n(32), .RESET_PC(32'h0000_0000)) dut0 (
      .clk(clk), .rst(rst0), .freeze(freeze0), .branch_taken(bt0), .branch_addr(ba0),
      .PC(pc0), .instruction(instr0), .if_pc_plus4(pc4_0), .if_instruction(ins_out0),
      .if_valid(valid0)
`ifdef IF_PERF_COUNT_EN
      , .fetch_count(fc0), .bubble_count(bc0)
`endif
   );

   instruction_fetch #(.n(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
      .clk(clk), .rst(rst1), .freeze(1'b0), .branch_taken(1'b0), .branch_addr(32'h0),
      .PC(pc1), .instruction(instr1), .if_pc_plus4(pc4_1), .if_instruction(ins_out1),
      .if_valid(valid1)
`ifdef IF_PERF_COUNT_EN
      , .fetch_count(fc1), .bubble_count(bc1)
`endif
   );

`ifndef IF_PERF_COUNT_EN
   assign fc0 = '0;
   assign bc0 = '0;
   assign fc1 = '0;
   assign bc1 = '0;
`endif

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endfunction

   // Inputs change on negedge; the expected state after the following posedge is queued.
   task automatic step0(input logic r, input logic f, input logic b, input logic [31:0] a,
                        input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ep4,
                        input logic ev);
      exp_t e;
      @(negedge clk);
      rst0 = r; freeze0 = f; bt0 = b; ba0 = a;
      e.pc = epc; e.instr = ei; e.pc4 = ep4; e.valid = ev; e.fcnt = '0; e.bcnt = '0;
      q0.push_back(e);
      $display("dut0 tx: rst=%b frz=%b br=%b addr=%h -> pc=%h instr=%h pc4=%h v=%b",
               r, f, b, a, epc, ei, ep4, ev);
   endtask

   task automatic step1(input logic r, input logic [31:0] epc, input logic [31:0] ei,
                        input logic [31:0] ep4, input logic ev,
                        input logic [31:0] efc, input logic [31:0] ebc);
      exp_t e;
      @(negedge clk);
      rst1 = r;
      e.pc = epc; e.instr = ei; e.pc4 = ep4; e.valid = ev; e.fcnt = efc; e.bcnt = ebc;
      q1.push_back(e);
      $display("dut1 tx: rst=%b -> pc=%h instr=%h pc4=%h v=%b fc=%0d bc=%0d",
               r, epc, ei, ep4, ev, efc, ebc);
   endtask

   // Monitor: samples 1 time unit after every posedge and retires one queued expectation per DUT.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("dut0.PC", pc0, e.pc);
            chk("dut0.if_instruction", ins_out0, e.instr);
            chk("dut0.if_pc_plus4", pc4_0, e.pc4);
            chk("dut0.if_valid", {31'b0, valid0}, {31'b0, e.valid});
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("dut1.PC", pc1, e.pc);
            chk("dut1.if_instruction", ins_out1, e.instr);
            chk("dut1.if_pc_plus4", pc4_1, e.pc4);
            chk("dut1.if_valid", {31'b0, valid1}, {31'b0, e.valid});
`ifdef IF_PERF_COUNT_EN
            chk("dut1.fetch_count", fc1, e.fcnt);
            chk("dut1.bubble_count", bc1, e.bcnt);
`endif
         end
      end
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h2408_0000 | 32'(i);

      // Reset held 3 cycles, BOOT bubble, then free run of 8 fetches
      repeat (3) step0(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      for (int k = 0; k < 8; k++)
         step0(1, 0, 0, 32'h0, 32'(4 * (k + 1)), mem[k], 32'(4 * (k + 1)), 1);

      // Freeze for 2 cycles at PC=12
      step0(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'd4,  mem[0], 32'd4,  1);
      step0(1, 0, 0, 32'h0, 32'd8,  mem[1], 32'd8,  1);
      step0(1, 0, 0, 32'h0, 32'd12, mem[2], 32'd12, 1);
      step0(1, 1, 0, 32'h0, 32'd12, mem[2], 32'd12, 1);
      step0(1, 1, 0, 32'h0, 32'd12, mem[2], 32'd12, 1);
      step0(1, 0, 0, 32'h0, 32'd16, mem[3], 32'd16, 1);

      // Branch to 0x14 at PC=8, then a branch with unaligned target bits
      step0(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'd4, mem[0], 32'd4, 1);
      step0(1, 0, 0, 32'h0, 32'd8, mem[1], 32'd8, 1);
      step0(1, 0, 1, 32'h14, 32'h14, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0,  32'h18, mem[5], 32'h18, 1);
      step0(1, 0, 1, 32'h2B, 32'h28, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0,  32'h2C, mem[10], 32'h2C, 1);

      // Branch and freeze together: branch wins; freeze alone then holds the bubble
      step0(1, 1, 1, 32'h4, 32'h4, 32'h0, 32'h0, 0);
      step0(1, 1, 0, 32'h0, 32'h4, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'h8, mem[1], 32'h8, 1);

      // Reset during a stall and during a branch
      step0(0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'h4, mem[0], 32'h4, 1);
      step0(0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      step0(1, 0, 0, 32'h0, 32'h4, mem[0], 32'h4, 1);
      @(negedge clk);
      rst0 = 1'b0;

      // Wrap-around from RESET_PC=0xFFFFFFFC
      step1(0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'd0, 32'd0);
      step1(1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 32'd0, 32'd1);
      step1(1, 32'h0, mem[63], 32'h0, 1, 32'd1, 32'd1);
      step1(1, 32'h4, mem[0],  32'h4, 1, 32'd2, 32'd1);

      repeat (3) @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
